// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Purpose:
//   Shares the single register-file write port (A3/WD3/WE3) between two
//   writeback requesters using a valid/ready handshake per requester.
//   A registered output stage drives the register file directly.
//   A per-register busy scoreboard is also kept here. A register is marked
//   busy at issue (reserve) and freed at commit. The control unit reads it
//   for hazard detection.
//
// Configuration:
//   ARB_ROUND_ROBIN_EN  defined   : on contention, the requester that was
//                                   not granted last wins (alternating).
//                       undefined : fixed priority, req0 always wins.
//
// Ports:
//   clk                  clock, all state updates on posedge
//   rst                  synchronous active-high reset
//   req0_valid/addr/data requester 0 write request
//   req0_ready           requester 0 handshake completes this cycle
//   req1_valid/addr/data requester 1 write request
//   req1_ready           requester 1 handshake completes this cycle
//   rsv_valid/rsv_addr   issue-time reservation of a destination register
//   wr_en/addr/data      register file WE3 / A3 / WD3
//   busy                 scoreboard; busy[i]=1 means a write to xi is pending
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int S = 32,
  parameter int N = 32,
  localparam int M = $clog2(S)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [M-1:0] req0_addr,
  input  logic [N-1:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [M-1:0] req1_addr,
  input  logic [N-1:0] req1_data,
  output logic         req1_ready,
  input  logic         rsv_valid,
  input  logic [M-1:0] rsv_addr,
  output logic         wr_en,
  output logic [M-1:0] wr_addr,
  output logic [N-1:0] wr_data,
  output logic [S-1:0] busy
);

  logic         grant0, grant1;

  logic         wr_en_q,   wr_en_d;
  logic [M-1:0] wr_addr_q, wr_addr_d;
  logic [N-1:0] wr_data_q, wr_data_d;
  logic [S-1:0] busy_q,    busy_d;

`ifdef ARB_ROUND_ROBIN_EN
  // Records which requester won the most recent transfer (1 = req1).
  logic         last_grant_q, last_grant_d;
`endif

  // -------------------------------------------------------------------------
  // Grant: exactly one requester is granted whenever any is valid and the
  // block is out of reset. ready is the grant itself, so it is purely
  // combinational from valid and the priority state.
  // -------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
        // The side that did not win last time takes this contention.
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
`else
        grant0 = 1'b1;
`endif
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant0 || grant1) begin
      last_grant_d = grant1;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Output stage: a transfer loads address/data for the next cycle. Writes
  // to x0 complete the handshake and still update address/data, but never
  // raise the write enable. With no transfer, address/data hold.
  // -------------------------------------------------------------------------
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (grant0) begin
      wr_en_d   = (req0_addr != '0);
      wr_addr_d = req0_addr;
      wr_data_d = req0_data;
    end else if (grant1) begin
      wr_en_d   = (req1_addr != '0);
      wr_addr_d = req1_addr;
      wr_data_d = req1_data;
    end
  end

  // -------------------------------------------------------------------------
  // Scoreboard: the commit visible this cycle clears its register. The
  // reserve is applied afterwards so that a same-edge reserve of the same
  // register leaves it busy. x0 can never be busy.
  // -------------------------------------------------------------------------
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q) begin
      busy_d[wr_addr_q] = 1'b0;
    end
    if (rsv_valid) begin
      busy_d[rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Self-checking bench for regfile_write_arbiter (S=32, N=32). Each handshake
// the bench expects pushes the write it should produce onto a queue. A
// monitor pops the queue and compares whenever the DUT raises wr_en.
// Grant, wr_en and busy are predicted by a small behavioural model.
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;

  localparam int S = 32;
  localparam int N = 32;
  localparam int M = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid, rsv_valid;
  logic [M-1:0] req0_addr, req1_addr, rsv_addr;
  logic [N-1:0] req0_data, req1_data;
  logic         req0_ready, req1_ready;
  logic         wr_en;
  logic [M-1:0] wr_addr;
  logic [N-1:0] wr_data;
  logic [S-1:0] busy;

  typedef struct packed {
    logic [M-1:0] addr;
    logic [N-1:0] data;
  } wr_t;

  wr_t          exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;

  // Behavioural model state.
  logic         model_last = 1'b1;
  logic [S-1:0] model_busy = '0;
  logic         pend_en    = 1'b0;
  logic [M-1:0] pend_addr  = '0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.S(S), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rsv_valid  (rsv_valid),
    .rsv_addr   (rsv_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  // Commit monitor: every write the DUT performs must match the oldest
  // expected write.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL commit_unexpected: got addr=%0d data=%h, expected no write",
                 wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== {e.addr, e.data}) begin
          n_bad++;
          $display("FAIL commit_data: got addr=%0d data=%h, expected addr=%0d data=%h",
                   wr_addr, wr_data, e.addr, e.data);
        end
      end
    end
  end

  // One clock cycle of stimulus. Inputs are applied just after a posedge.
  // ready is checked at the negedge and state is checked 1ns after the next
  // posedge. g0/g1 report the grants the model expected.
  task automatic cycle(input logic v0, input logic [M-1:0] a0, input logic [N-1:0] d0,
                       input logic v1, input logic [M-1:0] a1, input logic [N-1:0] d1,
                       input logic rv, input logic [M-1:0] ra, input logic r,
                       output logic g0, output logic g1);
    logic         eg0, eg1;
    logic [M-1:0] ga;
    logic [N-1:0] gd;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    rsv_valid  = rv; rsv_addr  = ra; rst = r;

    @(negedge clk);
    eg0 = 1'b0; eg1 = 1'b0;
    if (!r) begin
      if (v0 && v1) begin
`ifdef ARB_ROUND_ROBIN_EN
        eg0 = model_last; eg1 = ~model_last;
`else
        eg0 = 1'b1;
`endif
      end else begin
        eg0 = v0; eg1 = v1;
      end
    end
    n_cmp++;
    if ({req0_ready, req1_ready} !== {eg0, eg1}) begin
      n_bad++;
      $display("FAIL ready: got r0=%b r1=%b, expected r0=%b r1=%b",
               req0_ready, req1_ready, eg0, eg1);
    end
    ga = eg0 ? a0 : a1;
    gd = eg0 ? d0 : d1;

    @(posedge clk);
    // Advance the model across this edge.
    if (r) begin
      model_busy = '0; pend_en = 1'b0; pend_addr = '0; model_last = 1'b1;
    end else begin
      if (pend_en) model_busy[pend_addr] = 1'b0;
      if (rv && ra != '0) model_busy[ra] = 1'b1;
      pend_en = (eg0 || eg1) && ga != '0;
      if (eg0 || eg1) begin
        pend_addr  = ga;
        model_last = eg1;
      end
      if (pend_en) exp_q.push_back('{addr: ga, data: gd});
    end
    #1;
    n_cmp++;
    if (wr_en !== pend_en) begin
      n_bad++;
      $display("FAIL wr_en: got %b, expected %b", wr_en, pend_en);
    end
    n_cmp++;
    if (busy !== model_busy) begin
      n_bad++;
      $display("FAIL busy: got %h, expected %h", busy, model_busy);
    end
    if (eg0 || eg1) begin
      n_cmp++;
      if ({wr_addr, wr_data} !== {ga, gd}) begin
        n_bad++;
        $display("FAIL wr_port: got addr=%0d data=%h, expected addr=%0d data=%h",
                 wr_addr, wr_data, ga, gd);
      end
    end
    g0 = eg0; g1 = eg1;
  endtask

  task automatic idle(input int n);
    logic g0, g1;
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
  endtask

  task automatic test_reset();
    logic g0, g1;
    // Both requesters valid while reset is held: neither may be granted.
    cycle(1, 5'd3, 32'h3, 1, 5'd4, 32'h4, 1, 5'd6, 1, g0, g1);
    cycle(1, 5'd3, 32'h3, 1, 5'd4, 32'h4, 1, 5'd6, 1, g0, g1);
    n_cmp++;
    if ({wr_en, wr_addr, wr_data, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got en=%b addr=%0d data=%h busy=%h, expected all zero",
               wr_en, wr_addr, wr_data, busy);
    end
    idle(1);
  endtask

  task automatic test_single_write();
    logic g0, g1;
    cycle(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, g0, g1);
    n_cmp++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      n_bad++;
      $display("FAIL single_write: got en=%b addr=%0d data=%h, expected en=1 addr=5 data=deadbeef",
               wr_en, wr_addr, wr_data);
    end
    idle(1);
    n_cmp++;
    if (wr_en !== 1'b0) begin
      n_bad++;
      $display("FAIL single_write_end: got wr_en=%b, expected 0", wr_en);
    end
  endtask

  task automatic test_contention();
    logic [N-1:0] d0, d1;
    logic         g0, g1;
    int           wins0, wins1;
    logic         prev1;
    int           alt_bad;
    d0 = 32'h11; d1 = 32'h22;
    wins0 = 0; wins1 = 0; alt_bad = 0; prev1 = 1'bx;
    for (int i = 0; i < 4; i++) begin
      cycle(1, 5'd1, d0, 1, 5'd2, d1, 0, 0, 0, g0, g1);
      if (g0) begin wins0++; d0 = d0 + 32'h100; end
      if (g1) begin wins1++; d1 = d1 + 32'h100; end
      if (i > 0 && g1 === prev1) alt_bad++;
      prev1 = g1;
    end
    idle(1);
    n_cmp++;
`ifdef ARB_ROUND_ROBIN_EN
    if (wins0 != 2 || wins1 != 2 || alt_bad != 0) begin
      n_bad++;
      $display("FAIL contention_rr: got wins0=%0d wins1=%0d non_alternating=%0d, expected 2/2/0",
               wins0, wins1, alt_bad);
    end
`else
    if (wins0 != 4 || wins1 != 0) begin
      n_bad++;
      $display("FAIL contention_fixed: got wins0=%0d wins1=%0d, expected 4/0", wins0, wins1);
    end
`endif
  endtask

  task automatic test_scoreboard();
    logic g0, g1;
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd7, 0, g0, g1);
    idle(2);
    n_cmp++;
    if (busy[7] !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_reserved: got busy[7]=%b, expected 1", busy[7]);
    end
    // Write to x7 three cycles after the reserve; still busy until commit.
    cycle(0, 0, 0, 1, 5'd7, 32'h77, 0, 0, 0, g0, g1);
    n_cmp++;
    if (busy[7] !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_before_commit: got busy[7]=%b, expected 1", busy[7]);
    end
    idle(1);
    n_cmp++;
    if (busy[7] !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_cleared: got busy[7]=%b, expected 0", busy[7]);
    end
    // Reserve again, write, and re-reserve on the commit edge; the
    // reservation must win over the clear.
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd7, 0, g0, g1);
    cycle(0, 0, 0, 1, 5'd7, 32'h78, 0, 0, 0, g0, g1);
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd7, 0, g0, g1);
    n_cmp++;
    if (busy[7] !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_rsv_wins: got busy[7]=%b, expected 1", busy[7]);
    end
    cycle(1, 5'd7, 32'h79, 0, 0, 0, 0, 0, 0, g0, g1);
    idle(1);
    n_cmp++;
    if (busy[7] !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_final_clear: got busy[7]=%b, expected 0", busy[7]);
    end
  endtask

  task automatic test_x0();
    logic g0, g1;
    cycle(1, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 1, 5'd0, 0, g0, g1);
    n_cmp++;
    if ({g0, wr_en, wr_addr, wr_data, busy[0]} !== {1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 1'b0}) begin
      n_bad++;
      $display("FAIL x0_write: got en=%b addr=%0d data=%h busy0=%b, expected en=0 addr=0 data=ffffffff busy0=0",
               wr_en, wr_addr, wr_data, busy[0]);
    end
    idle(1);
  endtask

  task automatic test_reset_mid();
    logic g0, g1;
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd9, 0, g0, g1);
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd12, 0, g0, g1);
    cycle(0, 0, 0, 1, 5'd9, 32'h99, 0, 0, 0, g0, g1);
    // Reset in the cycle after the transfer, with both requesters pending.
    cycle(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 1, 5'd13, 1, g0, g1);
    n_cmp++;
    if ({wr_en, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: got wr_en=%b busy=%h, expected 0 and 0", wr_en, busy);
    end
    cycle(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, 0, 0, g0, g1);
    n_cmp++;
    if ({g0, g1} !== 2'b10) begin
      n_bad++;
      $display("FAIL reset_priority: got grants r0=%b r1=%b, expected r0=1 r1=0", g0, g1);
    end
    idle(2);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 0; req0_addr = 0; req0_data = 0;
    req1_valid = 0; req1_addr = 0; req1_data = 0;
    rsv_valid  = 0; rsv_addr  = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_write();
    test_contention();
    test_scoreboard();
    test_x0();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL commits_missing: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port (A3/WD3/WE3) between two writeback requesters, e.g. req0 = ALU writeback and req1 = load/multi-cycle unit.
- Uses a valid/ready handshake per requester and a registered output stage that drives the register file directly.
- Keeps a per-register busy scoreboard (reserve at issue, clear at commit) for hazard detection by the control unit.

Parameters:
- S, 32, number of architectural registers (scoreboard width).
- N, 32, data width of write data.
- M (localparam), $clog2(S), register address width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; synchronous, active-high.
- req0_valid  input  1  requester 0 has a write pending.
- req0_addr  input  M  destination register of requester 0.
- req0_data  input  N  write data of requester 0.
- req0_ready  output  1  requester 0 handshake completes this cycle.
- req1_valid, req1_addr, req1_data, req1_ready  same as above, for requester 1.
- rsv_valid  input  1  reserve a destination register (issue-time).
- rsv_addr  input  M  register to mark busy.
- wr_en  output  1  to register file WE3.
- wr_addr  output  M  to register file A3.
- wr_data  output  N  to register file WD3.
- busy  output  S  scoreboard; busy[i]=1 means a write to xi is outstanding.

Behaviour:
- Handshake and grant:
  - Transfer occurs on a posedge where reqX_valid=1 and reqX_ready=1.
  - ready is combinational from valid and the priority state.
  - A requester holds valid/addr/data stable until ready.
  - The port accepts one write per cycle, so exactly one requester is granted whenever any is valid.
  - Only one valid: that requester is granted.
  - Both valid: arbitration per Optional Feature; the loser's ready=0 and it retries.
  - While rst=1: both ready=0.
- Output stage (latency 1): a transfer at edge k drives wr_addr/wr_data with the granted request and wr_en=1 for cycle k+1. The register file writes at edge k+1. No transfer at edge k gives wr_en=0 in cycle k+1; wr_addr/wr_data hold their last value.
- Writes to x0: the handshake completes normally, but wr_en stays 0 (request dropped). wr_addr/wr_data still update.
- Scoreboard:
  - On posedge with rsv_valid=1 and rsv_addr!=0: busy[rsv_addr] is set.
  - On posedge with wr_en=1: busy[wr_addr] is cleared.
  - Same edge, same address, reserve and clear: reserve wins, busy stays 1.
  - Reserve of an already-busy register: remains 1.
  - busy[0] is constantly 0.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, priority state = requester 0 favoured. A reset asserted mid-operation discards any request registered but not yet committed (wr_en forced 0 next cycle) and clears all busy bits.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last_grant register, reset value 1, updates on every transfer to the granted requester. On contention, the requester != last_grant wins, so sustained contention alternates 0,1,0,1…
- Undefined: fixed priority, req0 always wins contention; no last_grant register.

Test Plan:
- Reset, then idle: wr_en=0, busy=0, both ready=0 while rst=1.
- req0 writes x5=0xDEADBEEF, single-shot: req0_ready=1 that cycle; next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF; following cycle wr_en=0.
- Both valid for 4 cycles (req0→x1=0x11, req1→x2=0x22, each re-presenting new data after grant):
  - With ARB_ROUND_ROBIN_EN: commit order x1,x2,x1,x2.
  - Without it: req1_ready=0 throughout, four req0 commits.
- rsv x7, then 3 cycles later req1 writes x7=0x77: busy[7]=1 from the edge after rsv until the edge where wr_en=1 with wr_addr=7, then 0. Same-edge re-reserve of x7 keeps busy[7]=1.
- req0 writes x0=0xFFFFFFFF, and rsv of x0: handshake completes, wr_en stays 0, busy[0]=0.
- rst asserted the cycle after a req1 transfer to x9 with busy[9]=1: next cycle wr_en=0, busy=0. After release, the first contention is granted to req0.
